// File: rtl/sparse_adder_pkg.sv
// Shared definitions for the pipelined sparse-tree adder.
//   clog2_levels    : number of prefix-tree levels for a power-of-two width
//   MIN_SPARSITY    : smallest legal carry-select block width
//   MAX_PIPE_STAGES : deepest legal pipeline
//   SPARSE_ADDER_OPERAND_T(W) : operand bundle {a, b, cin, sub} of width W
package sparse_adder_pkg;

    localparam int unsigned MIN_SPARSITY    = 2;
    localparam int unsigned MAX_PIPE_STAGES = 3;

    // log2 of a power-of-two n (ceiling for other values)
    function automatic int unsigned clog2_levels(input int unsigned n);
        int unsigned levels;
        levels = 0;
        while ((32'd1 << levels) < n) begin
            levels++;
        end
        return levels;
    endfunction

endpackage

// Operand bundle; width-parametrised through a macro since packages take no parameters.
`ifndef SPARSE_ADDER_OPERAND_T
`define SPARSE_ADDER_OPERAND_T(W) struct packed { logic [(W)-1:0] a; logic [(W)-1:0] b; logic cin; logic sub; }
`endif

// File: rtl/carry_select_block.sv
// Carry-select block: conditional sums of one W-bit slice for block carry-in 0 and 1.
//   a, b  : slice operands (b already conditionally inverted)
//   p     : slice propagate (a ^ b)
//   sum0  : slice sum assuming carry-in 0
//   sum1  : slice sum assuming carry-in 1
module carry_select_block #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic [W-1:0] sum0,
    output logic [W-1:0] sum1
);

    logic c0;
    logic c1;

    // Two short ripple chains, one per assumed carry-in
    always_comb begin
        sum0 = '0;
        sum1 = '0;
        c0   = 1'b0;
        c1   = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            sum0[i] = p[i] ^ c0;
            sum1[i] = p[i] ^ c1;
            c0      = (a[i] & b[i]) | (p[i] & c0);
            c1      = (a[i] & b[i]) | (p[i] & c1);
        end
    end

endmodule

// File: rtl/pipelined_sparse_tree_adder.sv
// Pipelined sparse-tree adder/subtractor with valid/ready flow control.
// Sklansky prefix tree produces one carry per SPARSITY bits; carry-select
// blocks form the sum. 1..3 register stages (input / post-tree / output).
//   clk, rst_n           : clock, async active-low reset
//   in_valid, in_ready   : input handshake
//   operand_1, operand_2 : A, B
//   carry_in, sub        : add carry-in (ignored on sub), subtract select
//   out_valid, out_ready : output handshake
//   sum, carry_out, overflow, zero : registered result and flags
module pipelined_sparse_tree_adder
    import sparse_adder_pkg::*;
#(
    parameter int unsigned N_BIT       = 32,
    parameter int unsigned SPARSITY    = 4,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_BIT-1:0] operand_1,
    input  logic [N_BIT-1:0] operand_2,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_BIT-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned LEVELS   = clog2_levels(N_BIT);
    localparam int unsigned S_LEVELS = clog2_levels(SPARSITY);
    localparam int unsigned N_BLK    = N_BIT / SPARSITY;
    localparam int unsigned IDX_W    = LEVELS;

    typedef `SPARSE_ADDER_OPERAND_T(N_BIT) operand_t;

    typedef struct packed {
        logic [N_BIT-1:0] sum0;
        logic [N_BIT-1:0] sum1;
        logic [N_BLK-1:0] c;
        logic             cin;
        logic             a_msb;
        logic             p_msb;
    } mid_t;

    // Elaboration-time parameter checks
    if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_pipe
        $fatal(1, "PIPE_STAGES must be 1..3");
    end
    if (N_BIT < 8 || (N_BIT & (N_BIT - 1)) != 0) begin : g_bad_width
        $fatal(1, "N_BIT must be a power of 2 and >= 8");
    end
    if (SPARSITY < MIN_SPARSITY || SPARSITY > N_BIT / 2 || (SPARSITY & (SPARSITY - 1)) != 0) begin : g_bad_sparsity
        $fatal(1, "SPARSITY must be a power of 2 in 2..N_BIT/2");
    end

    operand_t         in_op_c;
    operand_t         op;
    logic             op_valid;
    logic             op_ready;
    mid_t             mid_c;
    mid_t             mid;
    logic             mid_valid;
    logic             mid_ready;
    logic             load_out;

    logic [N_BIT-1:0] b_eff;
    logic             cin_eff;
    logic [N_BIT-1:0] p_c;
    logic [N_BIT-1:0] tg;
    logic [N_BIT-1:0] tp;
    logic [N_BIT-1:0] sum0_c;
    logic [N_BIT-1:0] sum1_c;
    logic [N_BLK-1:0] c_c;

    logic [N_BLK-1:0] blk_cin;
    logic [N_BIT-1:0] sum_sel;
    logic             ov_c;
    logic             zero_c;

    assign in_op_c = '{a: operand_1, b: operand_2, cin: carry_in, sub: sub};

    // Optional input register
    if (PIPE_STAGES == 3) begin : g_in_reg
        logic     op_valid_q;
        operand_t op_q;

        assign in_ready = ~op_valid_q | op_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                op_valid_q <= 1'b0;
                op_q       <= '0;
            end else if (in_ready) begin
                op_valid_q <= in_valid;
                if (in_valid) begin
                    op_q <= in_op_c;
                end
            end
        end

        assign op_valid = op_valid_q;
        assign op       = op_q;
    end else begin : g_in_pass
        assign op_valid = in_valid;
        assign op       = in_op_c;
        assign in_ready = op_ready;
    end

    // Sparse Sklansky prefix tree; cin folded into bit 0 generate so every
    // block carry already includes it. Past S_LEVELS only block-top lanes update.
    always_comb begin
        b_eff   = op.sub ? ~op.b : op.b;
        cin_eff = op.sub | op.cin;
        p_c     = op.a ^ b_eff;
        tg      = op.a & b_eff;
        tp      = p_c;
        tg[0]   = tg[0] | (tp[0] & cin_eff);
        for (int unsigned l = 0; l < LEVELS; l++) begin
            for (int unsigned i = 0; i < N_BIT; i++) begin
                if ((((i >> l) & 32'd1) == 32'd1) &&
                    ((l < S_LEVELS) || ((i % SPARSITY) == (SPARSITY - 1)))) begin
                    tg[IDX_W'(i)] = tg[IDX_W'(i)] | (tp[IDX_W'(i)] & tg[IDX_W'(((i >> l) << l) - 1)]);
                    tp[IDX_W'(i)] = tp[IDX_W'(i)] & tp[IDX_W'(((i >> l) << l) - 1)];
                end
            end
        end
    end

    // Conditional sums per block and block carries from the tree
    for (genvar m = 0; m < N_BLK; m++) begin : g_blk
        carry_select_block #(
            .W (SPARSITY)
        ) u_csb (
            .a    (op.a[m*SPARSITY +: SPARSITY]),
            .b    (b_eff[m*SPARSITY +: SPARSITY]),
            .p    (p_c[m*SPARSITY +: SPARSITY]),
            .sum0 (sum0_c[m*SPARSITY +: SPARSITY]),
            .sum1 (sum1_c[m*SPARSITY +: SPARSITY])
        );
        assign c_c[m] = tg[m*SPARSITY + SPARSITY - 1];
    end

    assign mid_c = '{sum0:  sum0_c,
                     sum1:  sum1_c,
                     c:     c_c,
                     cin:   cin_eff,
                     a_msb: op.a[N_BIT-1],
                     p_msb: p_c[N_BIT-1]};

    // Optional post-tree register
    if (PIPE_STAGES >= 2) begin : g_mid_reg
        logic mid_valid_q;
        mid_t mid_q;

        assign op_ready = ~mid_valid_q | mid_ready;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mid_valid_q <= 1'b0;
                mid_q       <= '0;
            end else if (op_ready) begin
                mid_valid_q <= op_valid;
                if (op_valid) begin
                    mid_q <= mid_c;
                end
            end
        end

        assign mid_valid = mid_valid_q;
        assign mid       = mid_q;
    end else begin : g_mid_pass
        assign mid_valid = op_valid;
        assign mid       = mid_c;
        assign op_ready  = mid_ready;
    end

    // Block m selects on the carry out of block m-1; block 0 on cin
    assign blk_cin = {mid.c[N_BLK-2:0], mid.cin};

    for (genvar m = 0; m < N_BLK; m++) begin : g_sel
        assign sum_sel[m*SPARSITY +: SPARSITY] = blk_cin[m] ? mid.sum1[m*SPARSITY +: SPARSITY]
                                                            : mid.sum0[m*SPARSITY +: SPARSITY];
    end

    // Operand signs equal exactly when the MSB propagate is 0
    assign ov_c   = ~mid.p_msb & (sum_sel[N_BIT-1] ^ mid.a_msb);
    assign zero_c = (sum_sel == '0);

    // Output register; holds while stalled
    assign load_out  = ~out_valid | out_ready;
    assign mid_ready = load_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else if (load_out) begin
            out_valid <= mid_valid;
            if (mid_valid) begin
                sum       <= sum_sel;
                carry_out <= mid.c[N_BLK-1];
                overflow  <= ov_c;
                zero      <= zero_c;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_sparse_tree_adder.sv
// Self-checking bench for pipelined_sparse_tree_adder (32-bit, sparsity 4, 2 stages).
module tb_pipelined_sparse_tree_adder;

    localparam int unsigned N_BIT       = 32;
    localparam int unsigned SPARSITY    = 4;
    localparam int unsigned PIPE_STAGES = 2;

    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [N_BIT-1:0]  operand_1 = '0;
    logic [N_BIT-1:0]  operand_2 = '0;
    logic              carry_in  = 1'b0;
    logic              sub       = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [N_BIT-1:0]  sum;
    logic              carry_out;
    logic              overflow;
    logic              zero;

    int                n_vec  = 0;
    int                n_miss = 0;
    int                stalls = 0;
    logic [34:0]       exp_q[$];
    logic              hold_valid = 1'b0;
    logic [34:0]       held = '0;
    logic [34:0]       obs;
    logic              stop = 1'b0;
    logic [3:0]        pat  = 4'b1001;

    always #5 clk = ~clk;

    pipelined_sparse_tree_adder #(
        .N_BIT       (N_BIT),
        .SPARSITY    (SPARSITY),
        .PIPE_STAGES (PIPE_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    assign obs = {carry_out, overflow, zero, sum};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer arithmetic on the operands, {carry, overflow, zero, sum}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic s);
        longint      ua, ub, ur, sa, sb, sr;
        logic [31:0] res;
        logic        co, ov;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            ur = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end else begin
            ur = ua + ub + longint'(ci);
            sr = sa + sb + longint'(ci);
            co = ((ur >> 32) != 0);
        end
        res = 32'(ur);
        ov  = (sr > S_MAX) || (sr < S_MIN);
        return {co, ov, (res == 32'd0), res};
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    // Scoreboard: handshakes sampled at negedge, transfers happen at next posedge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'(obs), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(1), 64'(0));
                end else begin
                    check("result", 64'(obs), 64'(exp_q.pop_front()));
                end
                hold_valid = 1'b0;
            end else if (out_valid) begin
                hold_valid = 1'b1;
                held       = obs;
            end else begin
                hold_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(operand_1, operand_2, carry_in, sub));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic s);
        int w;
        operand_1 = a;
        operand_2 = b;
        carry_in  = ci;
        sub       = s;
        in_valid  = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            w++;
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin
            w++;
            @(negedge clk);
        end
        if (!out_valid) check({tag, "_timeout"}, 64'(0), 64'(1));
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input logic s, input logic [31:0] es,
                            input logic eco, input logic eov, input logic ez);
        drive_op(a, b, ci, s);
        wait_out(tag);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_flags"}, 64'({carry_out, overflow, zero}), 64'({eco, eov, ez}));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n, input bit rnd);
        stop = 1'b0;
        fork
            begin
                for (int k = 0; k < n; k++) begin
                    drive_op(rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                stop = 1'b1;
            end
            begin
                int k;
                k = 0;
                while (!stop) begin
                    out_ready = rnd ? 1'($urandom_range(0, 1)) : pat[2'(k)];
                    k++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_data", 64'(obs), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with latency check
        drive_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_not_yet_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("t1_out_valid", 64'(out_valid), 64'(1));
        check("t1_sum", 64'(sum), 64'(32'h8));
        check("t1_flags", 64'({carry_out, overflow, zero}), 64'(0));
        @(posedge clk);
        #1;

        // Boundary operands
        directed("t2_ripple",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed("t3_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("t3_sub_neg",  32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_cin_ign", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        directed("add_cin",     32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed("sub_min",     32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("sub_equal",   32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

        // Full throughput without backpressure
        stalls    = 0;
        out_ready = 1'b1;
        repeat (32) drive_op(rand_word(), rand_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("throughput_stalls", 64'(stalls), 64'(0));
        drain();

        // Backpressure: fixed 1,0,0,1 pattern, then random
        stream(16, 1'b0);
        stream(400, 1'b1);

        // Reset with a full pipe
        out_ready = 1'b0;
        drive_op(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0);
        drive_op(32'h0000_0300, 32'h0000_0400, 1'b0, 1'b0);
        operand_1 = 32'hDEAD_0000;
        operand_2 = 32'h0000_BEEF;
        in_valid  = 1'b1;
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'(0));
        check("full_out_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 64'(out_valid), 64'(0));
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        directed("post_rst_first", 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, 32'h0000_3333, 1'b0, 1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
